// File: rtl/csr_regfile.sv
// Control/status register file: CRMD, PRMD, ECFG, ESTAT, ERA, BADV, EENTRY, SAVE0-3, TID,
// exception/ertn state updates and interrupt pending. Optional timer under `CSR_TIMER_EN`.
module csr_regfile (
  input  logic        clk,
  input  logic        resetn,
  input  logic [13:0] csr_rd_num,
  output logic [31:0] csr_rd_value,
  input  logic        csr_we,
  input  logic [13:0] csr_wr_num,
  input  logic [31:0] csr_wr_mask,
  input  logic [31:0] csr_wr_value,
  input  logic [5:0]  wb_exc,
  input  logic        ertn_flush,
  input  logic [31:0] wb_pc,
  input  logic [31:0] wb_fault_vaddr,
  input  logic [7:0]  hw_int_in,
  input  logic        ipi_int_in,
  output logic [31:0] ex_entry,
  output logic [31:0] ertn_pc,
  output logic        has_int
);
  localparam logic [13:0] CSR_CRMD   = 14'h00;
  localparam logic [13:0] CSR_PRMD   = 14'h01;
  localparam logic [13:0] CSR_ECFG   = 14'h04;
  localparam logic [13:0] CSR_ESTAT  = 14'h05;
  localparam logic [13:0] CSR_ERA    = 14'h06;
  localparam logic [13:0] CSR_BADV   = 14'h07;
  localparam logic [13:0] CSR_EENTRY = 14'h0C;
  localparam logic [13:0] CSR_SAVE0  = 14'h30;
  localparam logic [13:0] CSR_SAVE1  = 14'h31;
  localparam logic [13:0] CSR_SAVE2  = 14'h32;
  localparam logic [13:0] CSR_SAVE3  = 14'h33;
  localparam logic [13:0] CSR_TID    = 14'h40;
  localparam logic [13:0] CSR_TCFG   = 14'h41;
  localparam logic [13:0] CSR_TVAL   = 14'h42;
  localparam logic [13:0] CSR_TICLR  = 14'h44;

  logic [1:0]  r_crmd_plv;
  logic        r_crmd_ie;
  logic        r_crmd_da;
  logic [1:0]  r_prmd_pplv;
  logic        r_prmd_pie;
  logic [12:0] r_ecfg_lie;
  logic [1:0]  r_estat_sw;
  logic [7:0]  r_estat_hw;
  logic        r_estat_ipi;
  logic [5:0]  r_estat_ecode;
  logic [31:0] r_era;
  logic [31:0] r_badv;
  logic [25:0] r_eentry;
  logic [31:0] r_save [4];
  logic [31:0] r_tid;
  logic        w_ti;
  logic [12:0] w_estat_is;
  logic [31:0] w_wr_new;
  logic [5:0]  w_ecode;
  logic        w_exc;
  logic        w_sel_adef;
  logic        w_sel_ale;

`ifdef CSR_TIMER_EN
  logic [31:0] r_tcfg;
  logic [31:0] r_tval;
  logic        r_ti;
  logic        w_we_tcfg;
  logic        w_ticlr_clr;
  logic        w_timer_fire;

  assign w_we_tcfg    = csr_we && (csr_wr_num == CSR_TCFG);
  assign w_ticlr_clr  = csr_we && (csr_wr_num == CSR_TICLR) && csr_wr_value[0] && csr_wr_mask[0];
  assign w_timer_fire = !w_we_tcfg && r_tcfg[0] && (r_tval == 32'h0);
  assign w_ti         = r_ti;

  // A fresh TCFG write always reloads; otherwise the counter runs only while enabled.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_tcfg <= 32'h0;
      r_tval <= 32'hFFFF_FFFF;
      r_ti   <= 1'b0;
    end else begin
      if (w_we_tcfg) begin
        r_tcfg <= w_wr_new;
        r_tval <= {w_wr_new[31:2], 2'b00};
      end else if (w_timer_fire) begin
        r_tval <= r_tcfg[1] ? {r_tcfg[31:2], 2'b00} : 32'hFFFF_FFFF;
      end else if (r_tcfg[0] && (r_tval != 32'hFFFF_FFFF)) begin
        r_tval <= r_tval - 32'h1;
      end
      if (w_ticlr_clr) r_ti <= 1'b0;
      if (w_timer_fire) r_ti <= 1'b1;
    end
  end
`else
  assign w_ti = 1'b0;
`endif

  assign w_estat_is = {r_estat_ipi, w_ti, 1'b0, r_estat_hw, r_estat_sw};

  function automatic logic [31:0] f_csr(input logic [13:0] num);
    f_csr = 32'h0;
    case (num)
      CSR_CRMD:   f_csr = {28'h0, r_crmd_da, r_crmd_ie, r_crmd_plv};
      CSR_PRMD:   f_csr = {29'h0, r_prmd_pie, r_prmd_pplv};
      CSR_ECFG:   f_csr = {19'h0, r_ecfg_lie};
      CSR_ESTAT:  f_csr = {10'h0, r_estat_ecode, 3'b000, w_estat_is};
      CSR_ERA:    f_csr = r_era;
      CSR_BADV:   f_csr = r_badv;
      CSR_EENTRY: f_csr = {r_eentry, 6'b0};
      CSR_SAVE0, CSR_SAVE1, CSR_SAVE2, CSR_SAVE3: f_csr = r_save[num[1:0]];
      CSR_TID:    f_csr = r_tid;
`ifdef CSR_TIMER_EN
      CSR_TCFG:   f_csr = r_tcfg;
      CSR_TVAL:   f_csr = r_tval;
`endif
      default:    f_csr = 32'h0;
    endcase
  endfunction

  // The write path merges against the current value of the addressed CSR.
  always_comb begin
    csr_rd_value = f_csr(csr_rd_num);
    w_wr_new     = (f_csr(csr_wr_num) & ~csr_wr_mask) | (csr_wr_value & csr_wr_mask);
  end

  always_comb begin
    w_ecode = 6'h00;
    if (wb_exc[0])      w_ecode = 6'h00;
    else if (wb_exc[5]) w_ecode = 6'h08;
    else if (wb_exc[1]) w_ecode = 6'h0D;
    else if (wb_exc[3]) w_ecode = 6'h0B;
    else if (wb_exc[2]) w_ecode = 6'h0C;
    else if (wb_exc[4]) w_ecode = 6'h09;
  end

  assign w_exc      = |wb_exc;
  assign w_sel_adef = !wb_exc[0] && wb_exc[5];
  assign w_sel_ale  = (wb_exc == 6'b010000);

  // Later assignments win: exception over ertn over software writes, per field.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_crmd_plv    <= 2'b00;
      r_crmd_ie     <= 1'b0;
      r_crmd_da     <= 1'b1;
      r_prmd_pplv   <= 2'b00;
      r_prmd_pie    <= 1'b0;
      r_ecfg_lie    <= 13'h0;
      r_estat_sw    <= 2'b00;
      r_estat_hw    <= 8'h0;
      r_estat_ipi   <= 1'b0;
      r_estat_ecode <= 6'h0;
      r_era         <= 32'h0;
      r_badv        <= 32'h0;
      r_eentry      <= 26'h0;
      r_tid         <= 32'h0;
      for (int i = 0; i < 4; i++) r_save[i] <= 32'h0;
    end else begin
      r_estat_hw  <= hw_int_in;
      r_estat_ipi <= ipi_int_in;
      if (csr_we) begin
        case (csr_wr_num)
          CSR_CRMD:   {r_crmd_da, r_crmd_ie, r_crmd_plv} <= w_wr_new[3:0];
          CSR_PRMD:   {r_prmd_pie, r_prmd_pplv} <= w_wr_new[2:0];
          CSR_ECFG:   r_ecfg_lie <= w_wr_new[12:0] & 13'h1BFF;
          CSR_ESTAT:  r_estat_sw <= w_wr_new[1:0];
          CSR_ERA:    r_era <= w_wr_new;
          CSR_BADV:   r_badv <= w_wr_new;
          CSR_EENTRY: r_eentry <= w_wr_new[31:6];
          CSR_SAVE0, CSR_SAVE1, CSR_SAVE2, CSR_SAVE3: r_save[csr_wr_num[1:0]] <= w_wr_new;
          CSR_TID:    r_tid <= w_wr_new;
          default:    ;
        endcase
      end
      if (ertn_flush) begin
        r_crmd_plv <= r_prmd_pplv;
        r_crmd_ie  <= r_prmd_pie;
      end
      if (w_exc) begin
        r_prmd_pplv   <= r_crmd_plv;
        r_prmd_pie    <= r_crmd_ie;
        r_crmd_plv    <= 2'b00;
        r_crmd_ie     <= 1'b0;
        r_era         <= wb_pc;
        r_estat_ecode <= w_ecode;
        if (w_sel_adef) r_badv <= wb_pc;
        if (w_sel_ale)  r_badv <= wb_fault_vaddr;
      end
    end
  end

  assign has_int  = (|(w_estat_is & r_ecfg_lie)) & r_crmd_ie;
  assign ex_entry = {r_eentry, 6'b0};
  assign ertn_pc  = r_era;

endmodule

// File: tb/tb_csr_regfile.sv
// Directed bench for csr_regfile: field masks, exception/ertn sequencing, interrupts, timer.
module tb_csr_regfile;
  logic        clk = 1'b0;
  logic        resetn;
  logic [13:0] csr_rd_num;
  logic [31:0] csr_rd_value;
  logic        csr_we;
  logic [13:0] csr_wr_num;
  logic [31:0] csr_wr_mask;
  logic [31:0] csr_wr_value;
  logic [5:0]  wb_exc;
  logic        ertn_flush;
  logic [31:0] wb_pc;
  logic [31:0] wb_fault_vaddr;
  logic [7:0]  hw_int_in;
  logic        ipi_int_in;
  logic [31:0] ex_entry;
  logic [31:0] ertn_pc;
  logic        has_int;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] v;

  csr_regfile dut (
    .clk(clk), .resetn(resetn),
    .csr_rd_num(csr_rd_num), .csr_rd_value(csr_rd_value),
    .csr_we(csr_we), .csr_wr_num(csr_wr_num), .csr_wr_mask(csr_wr_mask),
    .csr_wr_value(csr_wr_value),
    .wb_exc(wb_exc), .ertn_flush(ertn_flush), .wb_pc(wb_pc), .wb_fault_vaddr(wb_fault_vaddr),
    .hw_int_in(hw_int_in), .ipi_int_in(ipi_int_in),
    .ex_entry(ex_entry), .ertn_pc(ertn_pc), .has_int(has_int)
  );

  // clock: period 20, inputs change and outputs are sampled 1 ns after posedge
  always #10 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [13:0] num, output logic [31:0] val);
    csr_rd_num = num;
    #1;
    val = csr_rd_value;
  endtask

  task automatic chk_csr(input string tag, input logic [13:0] num, input logic [31:0] exp);
    logic [31:0] got;
    rd(num, got);
    chk(tag, got, exp);
  endtask

  task automatic wr(input logic [13:0] num, input logic [31:0] mask, input logic [31:0] val);
    csr_we = 1'b1; csr_wr_num = num; csr_wr_mask = mask; csr_wr_value = val;
    step();
    csr_we = 1'b0;
  endtask

  task automatic exc(input logic [5:0] code, input logic [31:0] pc, input logic [31:0] va);
    wb_exc = code; wb_pc = pc; wb_fault_vaddr = va;
    step();
    wb_exc = 6'b0;
  endtask

  initial begin
    resetn = 1'b0; csr_rd_num = 14'h0; csr_we = 1'b0; csr_wr_num = 14'h0;
    csr_wr_mask = 32'h0; csr_wr_value = 32'h0; wb_exc = 6'h0; ertn_flush = 1'b0;
    wb_pc = 32'h0; wb_fault_vaddr = 32'h0; hw_int_in = 8'h0; ipi_int_in = 1'b0;
    step(); step();
    resetn = 1'b1;

    chk_csr("reset_crmd", 14'h00, 32'h0000_0008);
    chk_csr("reset_prmd", 14'h01, 32'h0);
    chk_csr("reset_ecfg", 14'h04, 32'h0);
    chk_csr("reset_estat", 14'h05, 32'h0);
    chk("reset_has_int", {31'h0, has_int}, 32'h0);
`ifdef CSR_TIMER_EN
    chk_csr("reset_tval", 14'h42, 32'hFFFF_FFFF);
`else
    chk_csr("reset_tval", 14'h42, 32'h0);
`endif

    // masked writes and decode
    wr(14'h30, 32'hFFFF_FFFF, 32'hAAAA_AAAA);
    wr(14'h30, 32'h0000_FFFF, 32'h1234_5678);
    chk_csr("save0_mask", 14'h30, 32'hAAAA_5678);
    wr(14'h33, 32'hFFFF_FFFF, 32'hDEAD_BEEF);
    chk_csr("save3", 14'h33, 32'hDEAD_BEEF);
    chk_csr("save0_keep", 14'h30, 32'hAAAA_5678);
    wr(14'h02, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk_csr("unmapped_02", 14'h02, 32'h0);
    chk_csr("unmapped_34", 14'h34, 32'h0);
    wr(14'h00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk_csr("crmd_fields", 14'h00, 32'h0000_000F);
    wr(14'h00, 32'hFFFF_FFFF, 32'h0000_0007);
    chk_csr("crmd_7", 14'h00, 32'h0000_0007);
    wr(14'h04, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk_csr("ecfg_fields", 14'h04, 32'h0000_1BFF);
    wr(14'h04, 32'hFFFF_FFFF, 32'h0);
    wr(14'h0C, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk_csr("eentry_fields", 14'h0C, 32'hFFFF_FFC0);
    chk("ex_entry", ex_entry, 32'hFFFF_FFC0);
    wr(14'h40, 32'hFFFF_FFFF, 32'h1234_5678);
    chk_csr("tid", 14'h40, 32'h1234_5678);
    wr(14'h07, 32'hFFFF_FFFF, 32'h5555_5555);

    // SYS exception from CRMD=0x7
    exc(6'b001000, 32'h1C00_0100, 32'h0);
    chk_csr("sys_crmd", 14'h00, 32'h0);
    chk_csr("sys_prmd", 14'h01, 32'h0000_0007);
    chk_csr("sys_era", 14'h06, 32'h1C00_0100);
    chk_csr("sys_estat", 14'h05, 32'h000B_0000);
    chk_csr("sys_badv_keep", 14'h07, 32'h5555_5555);

    ertn_flush = 1'b1; step(); ertn_flush = 1'b0;
    chk_csr("ertn_crmd", 14'h00, 32'h0000_0007);
    chk("ertn_pc", ertn_pc, 32'h1C00_0100);

    exc(6'b110000, 32'h1C00_0004, 32'h0000_0008);
    chk_csr("adef_estat", 14'h05, 32'h0008_0000);
    chk_csr("adef_badv", 14'h07, 32'h1C00_0004);
    chk_csr("adef_crmd", 14'h00, 32'h0);

    exc(6'b010000, 32'h1C00_0008, 32'h0000_1234);
    chk_csr("ale_estat", 14'h05, 32'h0009_0000);
    chk_csr("ale_badv", 14'h07, 32'h0000_1234);
    chk_csr("ale_prmd", 14'h01, 32'h0);

    exc(6'b000101, 32'h1C00_000C, 32'h0000_9999);
    chk_csr("int_estat", 14'h05, 32'h0000_0000);
    chk_csr("int_badv_keep", 14'h07, 32'h0000_1234);
    chk("int_era", ertn_pc, 32'h1C00_000C);

    exc(6'b001110, 32'h1C00_0010, 32'h0);
    chk_csr("ine_estat", 14'h05, 32'h000D_0000);

    // exception and software CRMD write in the same cycle: only DA follows the write
    csr_we = 1'b1; csr_wr_num = 14'h00; csr_wr_mask = 32'hFFFF_FFFF; csr_wr_value = 32'hF;
    exc(6'b000100, 32'h1C00_0014, 32'h0);
    csr_we = 1'b0;
    chk_csr("exc_we_crmd", 14'h00, 32'h0000_0008);
    chk_csr("exc_we_estat", 14'h05, 32'h000C_0000);

    wr(14'h00, 32'hFFFF_FFFF, 32'h0000_0005);
    exc(6'b000100, 32'h1C00_0018, 32'h0);
    chk_csr("brk_prmd", 14'h01, 32'h0000_0005);
    // ertn and software CRMD write together: PLV/IE from PRMD, DA from the write
    ertn_flush = 1'b1;
    wr(14'h00, 32'hFFFF_FFFF, 32'h0000_000A);
    ertn_flush = 1'b0;
    chk_csr("ertn_we_crmd", 14'h00, 32'h0000_000D);
    wr(14'h00, 32'hFFFF_FFFF, 32'h0000_0007);

    // interrupt sampling and has_int gating
    hw_int_in = 8'hA5; ipi_int_in = 1'b1;
    step();
    chk_csr("hw_estat", 14'h05, 32'h000C_1294);
    chk("hw_noenable", {31'h0, has_int}, 32'h0);
    wr(14'h04, 32'hFFFF_FFFF, 32'h0000_0004);
    chk("hw_has_int", {31'h0, has_int}, 32'h1);
    wr(14'h00, 32'hFFFF_FFFF, 32'h0000_0003);
    chk("hw_ie_off", {31'h0, has_int}, 32'h0);
    wr(14'h00, 32'hFFFF_FFFF, 32'h0000_0007);
    hw_int_in = 8'h00; ipi_int_in = 1'b0;
    step();
    chk_csr("hw_clear_estat", 14'h05, 32'h000C_0000);
    chk("hw_clear_int", {31'h0, has_int}, 32'h0);
    wr(14'h05, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk_csr("sw_is", 14'h05, 32'h000C_0003);
    wr(14'h04, 32'hFFFF_FFFF, 32'h0000_0001);
    chk("sw_has_int", {31'h0, has_int}, 32'h1);
    wr(14'h05, 32'h0000_0003, 32'h0);
    chk("sw_cleared", {31'h0, has_int}, 32'h0);
    wr(14'h04, 32'hFFFF_FFFF, 32'h0);

`ifdef CSR_TIMER_EN
    wr(14'h04, 32'hFFFF_FFFF, 32'h0000_0800);
    wr(14'h41, 32'hFFFF_FFFF, 32'h0000_000B);
    chk_csr("tm_load", 14'h42, 32'h0000_0008);
    chk_csr("tm_tcfg", 14'h41, 32'h0000_000B);
    for (int i = 0; i < 8; i++) step();
    chk_csr("tm_zero", 14'h42, 32'h0);
    chk_csr("tm_not_yet", 14'h05, 32'h000C_0000);
    step();
    chk_csr("tm_ti", 14'h05, 32'h000C_0800);
    chk("tm_has_int", {31'h0, has_int}, 32'h1);
    chk_csr("tm_reload", 14'h42, 32'h0000_0008);
    wr(14'h44, 32'hFFFF_FFFF, 32'h0000_0001);
    chk_csr("tm_ticlr", 14'h05, 32'h000C_0000);
    chk("tm_int_off", {31'h0, has_int}, 32'h0);
    chk_csr("tm_ticlr_rd", 14'h44, 32'h0);
    chk_csr("tm_count7", 14'h42, 32'h0000_0007);
    for (int i = 0; i < 7; i++) step();
    wr(14'h44, 32'hFFFF_FFFF, 32'h0000_0001);
    chk_csr("tm_set_wins", 14'h05, 32'h000C_0800);
    wr(14'h44, 32'h0000_0001, 32'h0000_0001);
    // one-shot: InitVal 1, En, not periodic
    wr(14'h41, 32'hFFFF_FFFF, 32'h0000_0005);
    chk_csr("os_load", 14'h42, 32'h0000_0004);
    for (int i = 0; i < 4; i++) step();
    chk_csr("os_zero_noti", 14'h05, 32'h000C_0000);
    step();
    chk_csr("os_ti", 14'h05, 32'h000C_0800);
    chk_csr("os_wrap", 14'h42, 32'hFFFF_FFFF);
    step();
    chk_csr("os_halt", 14'h42, 32'hFFFF_FFFF);
    wr(14'h41, 32'hFFFF_FFFF, 32'h0);
    step();
    chk_csr("tm_off", 14'h42, 32'h0);
    wr(14'h44, 32'hFFFF_FFFF, 32'h0000_0001);
    wr(14'h04, 32'hFFFF_FFFF, 32'h0);
`else
    wr(14'h41, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    for (int i = 0; i < 4; i++) step();
    chk_csr("notm_tcfg", 14'h41, 32'h0);
    chk_csr("notm_tval", 14'h42, 32'h0);
    chk_csr("notm_estat", 14'h05, 32'h000C_0000);
`endif

    // reset overrides a concurrent write and exception
    resetn = 1'b0;
    csr_we = 1'b1; csr_wr_num = 14'h04; csr_wr_mask = 32'hFFFF_FFFF; csr_wr_value = 32'h1FFF;
    exc(6'b001000, 32'h1C00_0200, 32'h0);
    csr_we = 1'b0; resetn = 1'b1;
    chk_csr("rst_crmd", 14'h00, 32'h0000_0008);
    chk_csr("rst_ecfg", 14'h04, 32'h0);
    chk_csr("rst_estat", 14'h05, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
